// File: rtl/fx_accumulator.sv
// rtl/fx_accumulator.sv - Q8.8 saturating multi-term accumulator with start/valid/ready handshake
// Sums a programmed number of signed products onto an initial value; sticky overflow rides with the result.
module fx_accumulator #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] i_init,
  input  logic [CNT_W-1:0] i_count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] i_product,
  input  logic             i_ovf,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_valid,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // The arithmetic ignores the binary point; FRAC only has to describe a sane format.
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_range_unused
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   add_ext;
  logic             add_sat;
  logic [WIDTH-1:0] add_res;

  always_comb begin
    add_ext = {acc_q[WIDTH-1], acc_q} + {i_product[WIDTH-1], i_product};
    add_sat = add_ext[WIDTH] ^ add_ext[WIDTH-1];
    add_res = add_ext[WIDTH-1:0];
    if (add_sat) begin
      add_res = add_ext[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = i_init;
          rem_d   = i_count;
          ovf_d   = 1'b0;
          state_d = (i_count != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = add_res;
          rem_d = rem_q - CNT_W'(1);
          ovf_d = ovf_q | i_ovf | add_sat;
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they are flops, not decodes, yet still line up with the state.
  always_comb begin
    valid_d = (state_d == S_DONE);
    ready_d = (state_d == S_ACCUM);
    busy_d  = (state_d != S_IDLE);
    sum_d   = (state_d == S_DONE) ? acc_d : sum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign o_sum      = sum_q;
  assign o_valid    = valid_q;
  assign o_overflow = ovf_q;

endmodule
